// File: rtl/vram_arb.sv
// vram_arb -- single-port text/font VRAM arbiter for the NTSC character path.
//
// One synchronous RAM is shared between the raster character fetch and a host
// read/write port. Video fetch always wins the slot and has a fixed 2-cycle
// latency. The host receives the remaining slots through a req/ack handshake.
// A saturating wait counter flags a starved host.
//
// All state advances only on CK_i edges where CK_EE_i is high.
//
// Ports
//   CK_i, XARST_i        clock, asynchronous active-low reset
//   CK_EE_i, RST_i       clock enable, synchronous reset (qualified by CK_EE_i)
//   VREQ_i, VADRs_i      video fetch request pulse and address
//   VDATs_o, VVLD_o      video read data and its 1-cycle valid
//   HREQ_i, HWE_i        host request level, 1=write / 0=read
//   HADRs_i, HWDATs_i    host address and write data
//   HACK_o, HRDATs_o     host done pulse; read data valid with HACK_o on reads
//   HSTRV_o              host starved flag, sticky until the host is granted
//   RAM_ADRs_o, RAM_WE_o, RAM_WDATs_o   registered RAM controls
//   RAM_RDATs_i          RAM read data, valid 1 enabled cycle after address
module vram_arb #(
  parameter int C_ADR_W  = 11,
  parameter int C_DAT_W  = 8,
  parameter int C_STRV_N = 255
) (
  input  logic               CK_i,
  input  logic               XARST_i,
  input  logic               CK_EE_i,
  input  logic               RST_i,
  input  logic               VREQ_i,
  input  logic [C_ADR_W-1:0] VADRs_i,
  output logic [C_DAT_W-1:0] VDATs_o,
  output logic               VVLD_o,
  input  logic               HREQ_i,
  input  logic               HWE_i,
  input  logic [C_ADR_W-1:0] HADRs_i,
  input  logic [C_DAT_W-1:0] HWDATs_i,
  output logic               HACK_o,
  output logic [C_DAT_W-1:0] HRDATs_o,
  output logic               HSTRV_o,
  output logic [C_ADR_W-1:0] RAM_ADRs_o,
  output logic               RAM_WE_o,
  output logic [C_DAT_W-1:0] RAM_WDATs_o,
  input  logic [C_DAT_W-1:0] RAM_RDATs_i
);

  typedef enum logic [1:0] {IDLE, VRD, HWR, HRD} slot_t;

  // state is the slot registered on the RAM bus (stage p0); its data returns
  // one enabled cycle later into the p1 output registers.
  slot_t       state;
  slot_t       state_nxt;
  logic        host_grant;
  logic        host_busy;
  logic [7:0]  wait_ctr;
  logic [7:0]  wait_ctr_nxt;
  logic        strv_nxt;

  logic [C_DAT_W-1:0] vdat_p1;
  logic               vld_p1;
  logic [C_DAT_W-1:0] hrdat_p1;
  logic               hack_p1;
  logic [C_ADR_W-1:0] ram_adr_p0;
  logic               ram_we_p0;
  logic [C_DAT_W-1:0] ram_wdat_p0;
  logic               hstrv_r;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A read in flight occupies the bus slot tag; HACK_o high means the host has
  // not yet had a chance to drop its stale request, so it is ignored as well.
  assign host_busy = (state == HRD) || hack_p1;

  always_comb begin
    state_nxt  = IDLE;
    host_grant = 1'b0;
    if (VREQ_i) begin
      state_nxt = VRD;
    end else if (HREQ_i && !host_busy) begin
      state_nxt  = HWE_i ? HWR : HRD;
      host_grant = 1'b1;
    end
  end

  always_comb begin
    wait_ctr_nxt = wait_ctr;
    strv_nxt     = hstrv_r;
    if (host_grant) begin
      wait_ctr_nxt = 8'd0;
      strv_nxt     = 1'b0;
    end else if (HREQ_i) begin
      wait_ctr_nxt = sat_inc8(wait_ctr);
      strv_nxt     = hstrv_r || (int'(wait_ctr_nxt) >= C_STRV_N);
    end
  end

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      state <= IDLE;
    end else if (CK_EE_i) begin
      if (RST_i) state <= IDLE;
      else       state <= state_nxt;
    end
  end

  // ---- stage p0: slot issue onto the RAM bus ----
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      ram_adr_p0  <= '0;
      ram_we_p0   <= 1'b0;
      ram_wdat_p0 <= '0;
      wait_ctr    <= 8'd0;
      hstrv_r     <= 1'b0;
    end else if (CK_EE_i) begin
      if (RST_i) begin
        ram_adr_p0  <= '0;
        ram_we_p0   <= 1'b0;
        ram_wdat_p0 <= '0;
        wait_ctr    <= 8'd0;
        hstrv_r     <= 1'b0;
      end else begin
        if (state_nxt == VRD)   ram_adr_p0 <= VADRs_i;
        else if (host_grant)    ram_adr_p0 <= HADRs_i;
        ram_we_p0 <= (state_nxt == HWR);
        if (state_nxt == HWR)   ram_wdat_p0 <= HWDATs_i;
        wait_ctr <= wait_ctr_nxt;
        hstrv_r  <= strv_nxt;
      end
    end
  end

  // ---- stage p1: read data return, routed by the registered slot tag ----
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      vdat_p1  <= '0;
      vld_p1   <= 1'b0;
      hrdat_p1 <= '0;
      hack_p1  <= 1'b0;
    end else if (CK_EE_i) begin
      if (RST_i) begin
        vdat_p1  <= '0;
        vld_p1   <= 1'b0;
        hrdat_p1 <= '0;
        hack_p1  <= 1'b0;
      end else begin
        vld_p1 <= (state == VRD);
        if (state == VRD) vdat_p1 <= RAM_RDATs_i;
        if (state == HRD) hrdat_p1 <= RAM_RDATs_i;
        // Writes ack as they are issued; reads ack when their data returns.
        hack_p1 <= (state_nxt == HWR) || (state == HRD);
      end
    end
  end

  assign VDATs_o     = vdat_p1;
  assign VVLD_o      = vld_p1;
  assign HRDATs_o    = hrdat_p1;
  assign HACK_o      = hack_p1;
  assign HSTRV_o     = hstrv_r;
  assign RAM_ADRs_o  = ram_adr_p0;
  assign RAM_WE_o    = ram_we_p0;
  assign RAM_WDATs_o = ram_wdat_p0;

endmodule

// File: tb/tb_vram_arb.sv
module tb_vram_arb;

  logic        CK_i = 1'b0;
  logic        XARST_i, CK_EE_i, RST_i;
  logic        VREQ_i, HREQ_i, HWE_i;
  logic [10:0] VADRs_i, HADRs_i;
  logic [7:0]  HWDATs_i;
  logic [7:0]  VDATs_o, HRDATs_o, RAM_WDATs_o, RAM_RDATs_i;
  logic        VVLD_o, HACK_o, HSTRV_o, RAM_WE_o;
  logic [10:0] RAM_ADRs_o;

  vram_arb #(.C_ADR_W(11), .C_DAT_W(8), .C_STRV_N(255)) dut (
    .CK_i(CK_i), .XARST_i(XARST_i), .CK_EE_i(CK_EE_i), .RST_i(RST_i),
    .VREQ_i(VREQ_i), .VADRs_i(VADRs_i), .VDATs_o(VDATs_o), .VVLD_o(VVLD_o),
    .HREQ_i(HREQ_i), .HWE_i(HWE_i), .HADRs_i(HADRs_i), .HWDATs_i(HWDATs_i),
    .HACK_o(HACK_o), .HRDATs_o(HRDATs_o), .HSTRV_o(HSTRV_o),
    .RAM_ADRs_o(RAM_ADRs_o), .RAM_WE_o(RAM_WE_o), .RAM_WDATs_o(RAM_WDATs_o),
    .RAM_RDATs_i(RAM_RDATs_i)
  );

  always #5 CK_i = ~CK_i;

  int n_chk  = 0;
  int n_fail = 0;
  int ecnt   = 0;
  int ee_div = 1;
  int div_cnt = 0;

  // Clock enable generator: one enabled edge out of every ee_div.
  initial CK_EE_i = 1'b1;
  always @(negedge CK_i) begin
    div_cnt = (div_cnt + 1) % ee_div;
    CK_EE_i = (div_cnt == 0);
  end

  // RAM model: combinational read of the registered address, write on enable.
  function automatic logic [7:0] init_val(input logic [10:0] a);
    if (a == 11'h123) return 8'h5A;
    return a[7:0] ^ 8'h3C ^ {5'd0, a[10:8]};
  endfunction
  logic [7:0] wmem [2048];
  bit         wv   [2048];
  assign RAM_RDATs_i = wv[RAM_ADRs_o] ? wmem[RAM_ADRs_o] : init_val(RAM_ADRs_o);
  always @(posedge CK_i)
    if (CK_EE_i && RAM_WE_o) begin
      wmem[RAM_ADRs_o] <= RAM_WDATs_o;
      wv[RAM_ADRs_o]   <= 1'b1;
    end

  typedef struct { logic [7:0] dat; int due; } vexp_t;
  typedef struct { bit rd; logic [7:0] dat; int due; } hexp_t;
  typedef struct { logic [10:0] adr; logic [7:0] dat; int due; } wexp_t;
  vexp_t vq[$];
  hexp_t hq[$];
  wexp_t wq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: compares DUT output events against queued expectations.
  always @(posedge CK_i) begin : mon
    logic en;
    vexp_t v;
    hexp_t h;
    wexp_t w;
    en = CK_EE_i;
    #1;
    if (en) begin
      ecnt++;
      if (XARST_i) begin
        if (VVLD_o) begin
          if (vq.size() == 0) chk("vvld_unexpected", 32'd1, 32'd0);
          else begin
            v = vq.pop_front();
            chk("vdat", VDATs_o, v.dat);
            chk("vlat", ecnt, v.due);
          end
        end else if (vq.size() != 0 && vq[0].due <= ecnt) begin
          chk("vvld_missing", 32'd0, 32'd1);
          void'(vq.pop_front());
        end
        if (HACK_o) begin
          if (hq.size() == 0) chk("hack_unexpected", 32'd1, 32'd0);
          else begin
            h = hq.pop_front();
            chk("hlat", ecnt, h.due);
            if (h.rd) chk("hrdat", HRDATs_o, h.dat);
          end
        end else if (hq.size() != 0 && hq[0].due <= ecnt) begin
          chk("hack_missing", 32'd0, 32'd1);
          void'(hq.pop_front());
        end
        if (RAM_WE_o) begin
          if (wq.size() == 0) chk("we_unexpected", 32'd1, 32'd0);
          else begin
            w = wq.pop_front();
            chk("wr_adr", RAM_ADRs_o, w.adr);
            chk("wr_dat", RAM_WDATs_o, w.dat);
            chk("wr_lat", ecnt, w.due);
          end
        end else if (wq.size() != 0 && wq[0].due <= ecnt) begin
          chk("we_missing", 32'd0, 32'd1);
          void'(wq.pop_front());
        end
      end
    end
  end

  // Advance to the negedge after the next enabled clock edge.
  task automatic tick();
    int e0;
    e0 = ecnt;
    do @(negedge CK_i); while (ecnt == e0);
  endtask

  task automatic vid(input logic [10:0] a, input logic [7:0] exp);
    VREQ_i = 1'b1; VADRs_i = a;
    vq.push_back('{exp, ecnt + 2});
    tick();
    VREQ_i = 1'b0;
  endtask

  task automatic host_wr(input logic [10:0] a, input logic [7:0] d);
    HREQ_i = 1'b1; HWE_i = 1'b1; HADRs_i = a; HWDATs_i = d;
    wq.push_back('{a, d, ecnt + 1});
    hq.push_back('{1'b0, 8'h00, ecnt + 1});
    tick();
    tick();
    HREQ_i = 1'b0;
  endtask

  task automatic host_rd(input logic [10:0] a, input logic [7:0] exp);
    HREQ_i = 1'b1; HWE_i = 1'b0; HADRs_i = a;
    hq.push_back('{1'b1, exp, ecnt + 2});
    repeat (3) tick();
    HREQ_i = 1'b0;
  endtask

  // Video and host write requested together: video first, write next cycle.
  task automatic collide(input logic [10:0] va, input logic [10:0] ha, input logic [7:0] hd);
    VREQ_i = 1'b1; VADRs_i = va;
    HREQ_i = 1'b1; HWE_i = 1'b1; HADRs_i = ha; HWDATs_i = hd;
    vq.push_back('{init_val(va), ecnt + 2});
    wq.push_back('{ha, hd, ecnt + 2});
    hq.push_back('{1'b0, 8'h00, ecnt + 2});
    tick();
    VREQ_i = 1'b0;
    chk("collide_bus_adr", RAM_ADRs_o, va);
    chk("collide_bus_we", RAM_WE_o, 1'b0);
    tick();
    tick();
    HREQ_i = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vvld"}, VVLD_o, 1'b0);
    chk({tag, "_vdat"}, VDATs_o, 8'h00);
    chk({tag, "_hack"}, HACK_o, 1'b0);
    chk({tag, "_hrdat"}, HRDATs_o, 8'h00);
    chk({tag, "_hstrv"}, HSTRV_o, 1'b0);
    chk({tag, "_radr"}, RAM_ADRs_o, 11'h000);
    chk({tag, "_rwe"}, RAM_WE_o, 1'b0);
    chk({tag, "_rwdat"}, RAM_WDATs_o, 8'h00);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    XARST_i = 1'b0; RST_i = 1'b0;
    VREQ_i = 1'b0; VADRs_i = '0;
    HREQ_i = 1'b0; HWE_i = 1'b0; HADRs_i = '0; HWDATs_i = '0;
    repeat (3) @(negedge CK_i);
    chk_zero("reset");
    XARST_i = 1'b1;
    tick();

    // Video fetch, fixed 2-cycle latency, no write strobe.
    vid(11'h123, 8'h5A);
    chk("v1_bus_we", RAM_WE_o, 1'b0);
    tick(); tick();

    // Host write on an idle bus, then read it back.
    host_wr(11'h010, 8'hA5);
    host_rd(11'h010, 8'hA5);
    tick();

    collide(11'h055, 11'h011, 8'hC3);
    host_rd(11'h011, 8'hC3);
    tick(); tick();

    // Synchronous reset puts everything back to zero before the starvation run.
    RST_i = 1'b1;
    tick();
    RST_i = 1'b0;
    chk_zero("sreset");

    // Continuous video with the host waiting: starvation flag after 255 waits.
    HREQ_i = 1'b1; HWE_i = 1'b1; HADRs_i = 11'h200; HWDATs_i = 8'h77;
    for (int i = 0; i < 300; i++) begin
      VREQ_i = 1'b1; VADRs_i = 11'(12'h300 + i);
      vq.push_back('{init_val(11'(12'h300 + i)), ecnt + 2});
      tick();
      if (i + 1 == 254) chk("strv_254", HSTRV_o, 1'b0);
      if (i + 1 == 255) chk("strv_255", HSTRV_o, 1'b1);
      if (i + 1 == 300) chk("strv_300", HSTRV_o, 1'b1);
    end
    VREQ_i = 1'b0;
    wq.push_back('{11'h200, 8'h77, ecnt + 1});
    hq.push_back('{1'b0, 8'h00, ecnt + 1});
    tick();
    chk("strv_clear", HSTRV_o, 1'b0);
    tick();
    HREQ_i = 1'b0;
    tick(); tick();
    host_rd(11'h200, 8'h77);
    tick();

    // Same traffic with the clock enable high one cycle in eight.
    ee_div = 8;
    tick();
    vid(11'h123, 8'h5A);
    tick(); tick();
    host_wr(11'h020, 8'h3C);
    host_rd(11'h020, 8'h3C);
    collide(11'h456, 11'h021, 8'h96);
    host_rd(11'h021, 8'h96);
    tick(); tick();
    ee_div = 1;
    tick(); tick();

    // Asynchronous reset while a host read is in flight.
    HREQ_i = 1'b1; HWE_i = 1'b0; HADRs_i = 11'h010;
    tick();
    XARST_i = 1'b0;
    HREQ_i  = 1'b0;
    hq.delete();
    #1;
    chk_zero("areset");
    @(negedge CK_i);
    @(negedge CK_i);
    XARST_i = 1'b1;
    repeat (3) tick();
    chk("areset_no_hack", HACK_o, 1'b0);
    vid(11'h321, init_val(11'h321));
    repeat (4) tick();

    chk("vq_drained", vq.size(), 0);
    chk("hq_drained", hq.size(), 0);
    chk("wq_drained", wq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
